jk_modn_counter: RTL and testbench

Synchronous mod-N up/down counter whose state register is a bank of JK stages, one per count bit. It sits directly downstream of the JK flip-flop cell and uses it as the storage element. Per-bit J/K drive is derived from the next-state logic. The block serves as the team's general event/BCD counter and provides a terminal-count output for cascading digits.

---
 rtl/jk_modn_counter_pkg.sv | 21 ++
 rtl/jk_modn_counter_jk_stage.sv | 29 ++
 rtl/jk_modn_counter.sv | 112 +++++++++++
 tb/tb_jk_modn_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jk_modn_counter_pkg.sv
// Shared types and elaboration helpers for the JK-based mod-N counter.
package jk_modn_counter_pkg;

    // Encoded as {j, k} so a stage can cast its inputs straight into this type.
    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET0 = 2'b01,
        SET1   = 2'b10,
        TOGGLE = 2'b11
    } jk_cmd_t;

    function automatic int unsigned terminal_value(input int unsigned modulus);
        return modulus - 1;
    endfunction

    function automatic bit modulus_legal(input int unsigned width, input int unsigned modulus);
        return (width >= 1) && (width < 32) && (modulus >= 2) &&
               (64'(modulus) <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/jk_modn_counter_jk_stage.sv
// Single JK flip-flop bit with synchronous active-low reset.
module jk_stage
    import jk_modn_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    jk_cmd_t cmd;
    assign cmd = jk_cmd_t'({j, k});

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case (cmd)
                HOLD:   q <= q;
                RESET0: q <= 1'b0;
                SET1:   q <= 1'b1;
                TOGGLE: q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_modn_counter.sv
// Mod-N up/down counter whose state is a bank of JK stages; tc cascades digits.
module jk_modn_counter
    import jk_modn_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    generate
        if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
            $error("jk_modn_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // One extra bit so MODULUS == 2**WIDTH is representable in comparisons.
    localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] TERM_X = (WIDTH+1)'(terminal_value(MODULUS));

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   next_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   clamp_x;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_v;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             wrap_hit;
    logic             load_bad;

    always_comb begin
        cnt_x    = {1'b0, count};
        load_x   = {1'b0, load_val};
        load_bad = (load_x >= MOD_X);
        clamp_x  = load_bad ? TERM_X : load_x;
        load_v   = clamp_x[WIDTH-1:0];

        // Out-of-range states take the wrap branch in both directions.
        wrap_hit = 1'b0;
        next_x   = cnt_x;
        if (up) begin
            if (cnt_x >= TERM_X) begin
                next_x   = '0;
                wrap_hit = 1'b1;
            end else begin
                next_x = cnt_x + (WIDTH+1)'(1);
            end
        end else begin
            if ((cnt_x == '0) || (cnt_x > TERM_X)) begin
                next_x   = TERM_X;
                wrap_hit = 1'b1;
            end else begin
                next_x = cnt_x - (WIDTH+1)'(1);
            end
        end
        count_next = next_x[WIDTH-1:0];

        // Load forces each bit explicitly; counting only toggles bits that change.
        if (load) begin
            j_vec = load_v;
            k_vec = ~load_v;
        end else if (en) begin
            j_vec = count ^ count_next;
            k_vec = count ^ count_next;
        end else begin
            j_vec = '0;
            k_vec = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            jk_stage u_stage (
                .clk (clk),
                .rst (rst),
                .j   (j_vec[gi]),
                .k   (k_vec[gi]),
                .q   (count[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if (load_bad) begin
                err <= 1'b1;
            end
        end else if (en) begin
            wrap <= wrap_hit;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign tc = en & ~load & ((up & (cnt_x == TERM_X)) | (~up & (cnt_x == '0)));

endmodule

// File: tb/tb_jk_modn_counter.sv
// Self-checking bench: decimal counter with scoreboard, binary-modulus instance, two-digit cascade.
module tb_jk_modn_counter;

    localparam int W = 6;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main decimal counter
    logic       en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       tc, wrap, err;

    // binary-modulus counter
    logic       en16 = 1'b0, up16 = 1'b0, load16 = 1'b0;
    logic [3:0] lv16 = '0;
    logic [3:0] count16;
    logic       tc16, wrap16, err16;

    // two-digit cascade
    logic       c_en = 1'b0, c_up = 1'b1, c_load = 1'b0;
    logic [3:0] c_lv = '0;
    logic [3:0] c_count0, c_count1;
    logic       c_tc0, c_tc1, c_wrap0, c_wrap1, c_err0, c_err1;

    jk_modn_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .wrap(wrap), .err(err)
    );

    jk_modn_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .up(up16), .load(load16), .load_val(lv16),
        .count(count16), .tc(tc16), .wrap(wrap16), .err(err16)
    );

    jk_modn_counter #(.WIDTH(4), .MODULUS(10)) digit0 (
        .clk(clk), .rst(rst), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv),
        .count(c_count0), .tc(c_tc0), .wrap(c_wrap0), .err(c_err0)
    );

    jk_modn_counter #(.WIDTH(4), .MODULUS(10)) digit1 (
        .clk(clk), .rst(rst), .en(c_tc0), .up(c_up), .load(c_load), .load_val(c_lv),
        .count(c_count1), .tc(c_tc1), .wrap(c_wrap1), .err(c_err1)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int m_count = 0;
    int m_wrap  = 0;
    int m_err   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle on the main counter: checks tc before the edge and state after it.
    task automatic step(input logic r, input logic l, input logic [3:0] lv,
                        input logic e, input logic u);
        logic [W-1:0] exp;
        logic         exp_tc;
        @(negedge clk);
        rst = r; load = l; load_val = lv; en = e; up = u;
        #1;
        exp_tc = e && !l && ((u && m_count == 9) || (!u && m_count == 0));
        check_eq("tc", 32'(tc), 32'(exp_tc));
        if (!r) begin
            m_count = 0; m_wrap = 0; m_err = 0;
        end else if (l) begin
            m_wrap = 0;
            if (int'(lv) < 10) begin
                m_count = int'(lv);
            end else begin
                m_count = 9;
                m_err   = 1;
            end
        end else if (e) begin
            if (u) begin
                m_wrap  = (m_count == 9) ? 1 : 0;
                m_count = (m_count + 1) % 10;
            end else begin
                m_wrap  = (m_count == 0) ? 1 : 0;
                m_count = (m_count + 9) % 10;
            end
        end else begin
            m_wrap = 0;
        end
        exp_q.push_back({1'(m_err), 1'(m_wrap), 4'(m_count)});
        @(posedge clk);
        #1;
        check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_eq("state{err,wrap,count}", 32'({err, wrap, count}), 32'(exp));
        end
    endtask

    initial begin
        // 1: reset dominates load and en
        step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        check_eq("reset_count", 32'(count), 32'd0);

        // 2: up count through the wrap (first edge is the release edge)
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        check_eq("up_end", 32'(count), 32'd2);

        // 3: down count through zero
        step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        check_eq("down_end", 32'(count), 32'd8);

        // 4: load priority, clamp, sticky err
        step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        check_eq("load7", 32'(count), 32'd7);
        step(1'b1, 1'b1, 4'd13, 1'b1, 1'b1);
        check_eq("clamp_count", 32'(count), 32'd9);
        check_eq("clamp_err", 32'(err), 32'd1);
        step(1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
        check_eq("load_on_terminal", 32'(count), 32'd9);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        check_eq("err_sticky", 32'(err), 32'd1);

        // 5: hold and direction change
        step(1'b1, 1'b1, 4'd4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 1'b1, (i % 2 == 0));
        check_eq("toggle_end", 32'(count), 32'd4);

        // random mix
        for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // only reset clears err
        step(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check_eq("err_cleared", 32'(err), 32'd0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

        // 6a: MODULUS == 2**WIDTH
        @(negedge clk);
        load16 = 1'b1; lv16 = 4'd15; en16 = 1'b0; up16 = 1'b1;
        @(posedge clk); #1;
        check_eq("m16_load15", 32'(count16), 32'd15);
        check_eq("m16_err", 32'(err16), 32'd0);
        @(negedge clk);
        load16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
        #1;
        check_eq("m16_tc_up", 32'(tc16), 32'd1);
        @(posedge clk); #1;
        check_eq("m16_up_wrap_count", 32'(count16), 32'd0);
        check_eq("m16_up_wrap", 32'(wrap16), 32'd1);
        @(negedge clk);
        up16 = 1'b0;
        #1;
        check_eq("m16_tc_down", 32'(tc16), 32'd1);
        @(posedge clk); #1;
        check_eq("m16_down_wrap_count", 32'(count16), 32'd15);
        check_eq("m16_down_wrap", 32'(wrap16), 32'd1);
        @(negedge clk);
        en16 = 1'b0;
        @(posedge clk); #1;
        check_eq("m16_hold_count", 32'(count16), 32'd15);
        check_eq("m16_hold_wrap", 32'(wrap16), 32'd0);

        // 6b: two-digit cascade 00..99 -> 00
        @(negedge clk);
        check_eq("casc_start", 32'({c_count1, c_count0}), 32'h00);
        c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            check_eq("casc_value", 32'({c_count1, c_count0}),
                     32'({4'((k / 10) % 10), 4'(k % 10)}));
        end
        check_eq("casc_digit1_wrap", 32'(c_wrap1), 32'd1);
        @(negedge clk);
        c_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
